voice_sequencer: RTL and testbench

//  Frame scheduler and mixer in front of the multi_voice generator. On each sample tick it

---
 rtl/voice_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_voice_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sequencer.sv
// voice_sequencer: per-frame scheduler and mixer in front of the multi_voice generator.
// On a sample tick it snapshots every voice's settings, then for each voice starts
// the generator, waits for its sample (or a timeout), scales it by the voice gain and
// sums it into a signed 12-bit frame sample.
// Optional feature: define VOICE_SEQUENCER_CLIP_EN to saturate sample_o to [-512,511].
module voice_sequencer #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned GAIN_W     = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           sample_tick_i,
  input  logic [16*NUM_VOICES-1:0]       freq_words_i,
  input  logic [12*NUM_VOICES-1:0]       pw_words_i,
  input  logic [4*NUM_VOICES-1:0]        wave_sels_i,
  input  logic [GAIN_W*NUM_VOICES-1:0]   gains_i,
  output logic                           mv_start_o,
  output logic [1:0]                     mv_voice_o,
  output logic [15:0]                    mv_freq_o,
  output logic [11:0]                    mv_pw_o,
  output logic [3:0]                     mv_wave_sel_o,
  input  logic                           mv_ready_i,
  input  logic [9:0]                     mv_wave_i,
  output logic [11:0]                    sample_o,
  output logic                           sample_valid_o,
  output logic                           busy_o,
  output logic                           overrun_o,
  output logic                           timeout_o
);

  localparam int unsigned CntW      = $clog2(TIMEOUT + 1);
  localparam int unsigned ProdW     = GAIN_W + 12;
  localparam logic [1:0]  LastVoice = 2'(NUM_VOICES - 1);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StAcc, StOut} state_e;

  state_e                         state_q, state_d;
  logic [1:0]                     voice_q, voice_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [9:0]                     wave_q, wave_d;
  logic signed [11:0]             acc_q, acc_d;
  logic [16*NUM_VOICES-1:0]       freq_q, freq_d;
  logic [12*NUM_VOICES-1:0]       pw_q, pw_d;
  logic [4*NUM_VOICES-1:0]        sel_q, sel_d;
  logic [GAIN_W*NUM_VOICES-1:0]   gain_q, gain_d;
  logic [11:0]                    sample_q, sample_d;
  logic                           valid_q, valid_d;
  logic                           overrun_q, overrun_d;
  logic                           timeout_q, timeout_d;

  logic [GAIN_W-1:0]              gain_sel;
  logic signed [10:0]             s_val;
  logic signed [ProdW-1:0]        prod;
  logic signed [11:0]             contrib;
  logic signed [11:0]             clip_val;

  assign mv_start_o     = (state_q == StStart);
  assign busy_o         = (state_q != StIdle);
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;
  assign timeout_o      = timeout_q;
  assign mv_voice_o     = voice_q;

  // Route the snapshot fields of the active voice to the generator; holds in idle.
  always_comb begin
    mv_freq_o     = '0;
    mv_pw_o       = '0;
    mv_wave_sel_o = '0;
    gain_sel      = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_q == 2'(v)) begin
        mv_freq_o     = freq_q[16*v +: 16];
        mv_pw_o       = pw_q[12*v +: 12];
        mv_wave_sel_o = sel_q[4*v +: 4];
        gain_sel      = gain_q[GAIN_W*v +: GAIN_W];
      end
    end
  end

  // Centre the sample around zero, scale by gain, floor-divide by 2^GAIN_W.
  always_comb begin
    s_val   = $signed({1'b0, wave_q}) - 11'sd512;
    prod    = ProdW'(s_val) * ProdW'($signed({1'b0, gain_sel}));
    contrib = 12'(prod >>> GAIN_W);
  end

  // Output value of a finished frame, optionally saturated.
  always_comb begin
`ifdef VOICE_SEQUENCER_CLIP_EN
    if (acc_q > 12'sd511) begin
      clip_val = 12'sd511;
    end else if (acc_q < -12'sd512) begin
      clip_val = -12'sd512;
    end else begin
      clip_val = acc_q;
    end
`else
    clip_val = acc_q;
`endif
  end

  // Frame FSM next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    voice_d   = voice_q;
    cnt_d     = cnt_q;
    wave_d    = wave_q;
    acc_d     = acc_q;
    freq_d    = freq_q;
    pw_d      = pw_q;
    sel_d     = sel_q;
    gain_d    = gain_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    timeout_d = timeout_q;

    // A tick is only taken in idle; any tick during a frame is dropped and flagged.
    if (sample_tick_i && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (sample_tick_i) begin
          freq_d  = freq_words_i;
          pw_d    = pw_words_i;
          sel_d   = wave_sels_i;
          gain_d  = gains_i;
          acc_d   = '0;
          voice_d = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Ready wins even in the last allowed cycle; the wait lasts at most TIMEOUT cycles.
        if (mv_ready_i) begin
          wave_d  = mv_wave_i;
          state_d = StAcc;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          wave_d    = 10'd512;
          timeout_d = 1'b1;
          state_d   = StAcc;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAcc: begin
        acc_d = acc_q + contrib;
        if (voice_q == LastVoice) begin
          state_d = StOut;
        end else begin
          voice_d = voice_q + 2'd1;
          state_d = StStart;
        end
      end
      StOut: begin
        sample_d = clip_val;
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      voice_q   <= '0;
      cnt_q     <= '0;
      wave_q    <= '0;
      acc_q     <= '0;
      freq_q    <= '0;
      pw_q      <= '0;
      sel_q     <= '0;
      gain_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      voice_q   <= voice_d;
      cnt_q     <= cnt_d;
      wave_q    <= wave_d;
      acc_q     <= acc_d;
      freq_q    <= freq_d;
      pw_q      <= pw_d;
      sel_q     <= sel_d;
      gain_q    <= gain_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer with a behavioural generator that answers
// three cycles after each start (optionally never answering for one voice).
module tb_voice_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [47:0] freq;
  logic [35:0] pw;
  logic [11:0] sel;
  logic [23:0] gains;
  logic        mv_ready;
  logic [9:0]  mv_wave;
  logic        mv_start;
  logic [1:0]  mv_voice;
  logic [15:0] mv_freq;
  logic [11:0] mv_pw;
  logic [3:0]  mv_wave_sel;
  logic [11:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic        timeout;

  voice_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_tick_i  (tick),
    .freq_words_i   (freq),
    .pw_words_i     (pw),
    .wave_sels_i    (sel),
    .gains_i        (gains),
    .mv_start_o     (mv_start),
    .mv_voice_o     (mv_voice),
    .mv_freq_o      (mv_freq),
    .mv_pw_o        (mv_pw),
    .mv_wave_sel_o  (mv_wave_sel),
    .mv_ready_i     (mv_ready),
    .mv_wave_i      (mv_wave),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .busy_o         (busy),
    .overrun_o      (overrun),
    .timeout_o      (timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_tick   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Generator model
  logic [9:0] wave_tab [3];
  bit         stall_en    = 1'b0;
  logic [1:0] stall_voice = 2'd0;
  int         gd          = 0;
  logic [1:0] gcur        = 2'd0;

  always @(negedge clk) begin
    mv_ready = 1'b0;
    if (mv_start) begin
      gd   = 3;
      gcur = mv_voice;
    end else if (gd > 0) begin
      gd = gd - 1;
      if (gd == 0 && !(stall_en && gcur == stall_voice)) begin
        mv_ready = 1'b1;
        mv_wave  = wave_tab[gcur];
      end
    end
  end

  // Output monitor
  int          valid_cnt = 0;
  int          start_cnt = 0;
  int          valid_cyc = 0;
  logic        busy_at_valid;
  logic [1:0]  voice_log [$];
  logic [15:0] freq_log [$];

  always @(negedge clk) begin
    if (sample_valid) begin
      valid_cnt     = valid_cnt + 1;
      valid_cyc     = cyc;
      busy_at_valid = busy;
    end
    if (mv_start) begin
      start_cnt = start_cnt + 1;
      voice_log.push_back(mv_voice);
      freq_log.push_back(mv_freq);
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick   = 1'b1;
    t_tick = cyc;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_valid(input int n0, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (valid_cnt > n0) break;
    end
    @(negedge clk);
  endtask

  int v0;
  int s0;
  int exp_full;
  int exp_tmo;

  initial begin
`ifdef VOICE_SEQUENCER_CLIP_EN
    exp_full = 511;
    exp_tmo  = 511;
`else
    exp_full = 1527;
    exp_tmo  = 1018;
`endif
    rst      = 1'b1;
    tick     = 1'b0;
    freq     = '0;
    pw       = '0;
    sel      = '0;
    gains    = '0;
    mv_ready = 1'b0;
    mv_wave  = '0;
    wave_tab[0] = 10'd0;
    wave_tab[1] = 10'd0;
    wave_tab[2] = 10'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    repeat (20) @(negedge clk);
    check("rst_start_cnt", start_cnt, 0);
    check("rst_valid_cnt", valid_cnt, 0);
    check("rst_sample", sample, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    check("rst_voice", mv_voice, 0);
    check("rst_freq", mv_freq, 0);
    check("rst_pw_sel", {mv_pw, mv_wave_sel}, 0);

    // 2: full-scale on all voices
    gains = {8'd255, 8'd255, 8'd255};
    freq  = {16'h0300, 16'h0200, 16'h0100};
    wave_tab[0] = 10'd1023;
    wave_tab[1] = 10'd1023;
    wave_tab[2] = 10'd1023;
    v0 = valid_cnt;
    s0 = start_cnt;
    voice_log.delete();
    do_tick();
    check("t2_busy_after_tick", busy, 1);
    wait_valid(v0, 60);
    check("t2_valid_cnt", valid_cnt - v0, 1);
    check("t2_sample", $signed(sample), exp_full);
    check("t2_latency", valid_cyc - t_tick, 17);
    check("t2_busy_at_valid", busy_at_valid, 0);
    check("t2_starts", start_cnt - s0, 3);

    // 3: mixed gains, one negative contribution
    gains = {8'd255, 8'd128, 8'd0};
    wave_tab[0] = 10'd0;
    wave_tab[1] = 10'd0;
    wave_tab[2] = 10'd512;
    v0 = valid_cnt;
    voice_log.delete();
    do_tick();
    wait_valid(v0, 60);
    check("t3_sample", $signed(sample), -256);
    check("t3_voice_cnt", voice_log.size(), 3);
    if (voice_log.size() == 3) begin
      check("t3_voice0", voice_log[0], 0);
      check("t3_voice1", voice_log[1], 1);
      check("t3_voice2", voice_log[2], 2);
    end
    check("t3_timeout", timeout, 0);

    // 4: voice 1 never answers
    gains = {8'd255, 8'd255, 8'd255};
    wave_tab[0] = 10'd1023;
    wave_tab[1] = 10'd1023;
    wave_tab[2] = 10'd1023;
    stall_en    = 1'b1;
    stall_voice = 2'd1;
    v0 = valid_cnt;
    do_tick();
    wait_valid(v0, 80);
    stall_en = 1'b0;
    check("t4_valid_cnt", valid_cnt - v0, 1);
    check("t4_sample", $signed(sample), exp_tmo);
    check("t4_timeout", timeout, 1);
    check("t4_latency", valid_cyc - t_tick, 29);
    check("t4_overrun", overrun, 0);

    // 5: second tick while busy
    gains = {8'd255, 8'd128, 8'd0};
    wave_tab[0] = 10'd0;
    wave_tab[1] = 10'd0;
    wave_tab[2] = 10'd512;
    v0 = valid_cnt;
    do_tick();
    repeat (3) @(negedge clk);
    do_tick();
    repeat (50) @(negedge clk);
    check("t5_overrun", overrun, 1);
    check("t5_one_valid", valid_cnt - v0, 1);
    check("t5_sample", $signed(sample), -256);

    // 6: snapshot isolation, then reset mid-wait
    freq = {16'h3333, 16'h2222, 16'h1111};
    pw   = {12'h333, 12'h222, 12'h111};
    sel  = {4'h3, 4'h2, 4'h1};
    v0 = valid_cnt;
    freq_log.delete();
    do_tick();
    repeat (3) @(negedge clk);
    freq = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    pw   = {12'hCCC, 12'hBBB, 12'hAAA};
    wait_valid(v0, 60);
    check("t6_freq_cnt", freq_log.size(), 3);
    if (freq_log.size() == 3) begin
      check("t6_freq0", freq_log[0], 32'h1111);
      check("t6_freq1", freq_log[1], 32'h2222);
      check("t6_freq2", freq_log[2], 32'h3333);
    end
    check("t6_hold_freq", mv_freq, 32'h3333);
    check("t6_hold_pw", mv_pw, 32'h333);
    check("t6_hold_sel", mv_wave_sel, 3);

    v0 = valid_cnt;
    s0 = start_cnt;
    freq_log.delete();
    do_tick();
    @(negedge clk);
    check("t6_tick_after_overrun", start_cnt - s0, 1);
    check("t6_new_freq", mv_freq, 32'hAAAA);
    check("t6_busy_wait", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_freq", mv_freq, 0);
    check("t6_rst_voice", mv_voice, 0);
    check("t6_rst_flags", {overrun, timeout, sample_valid}, 0);
    check("t6_rst_sample", sample, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_no_valid", valid_cnt - v0, 0);
    check("t6_no_start", start_cnt - s0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
